spi_word_target: RTL and testbench
==================================

# spi_word_target

Parametrised SPI target (peripheral) that succeeds the byte-level SPI receiver. All SPI pins are oversampled into a single system clock domain, so every output is synchronous. It supports any of the four SPI modes, configurable word width, and back-to-back words within one chip-select frame. It also provides buffered receive and transmit handshakes with overrun and underrun reporting. It sits between the MCU SPI pins and the bus bridge / register file.

## Interface
- WIDTH, 8: bits per word (2..32), MSB first.
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge.
- SYNC_STAGES, 2: synchroniser flops on spi_cs_n, spi_sclk, spi_rx (minimum 2).
- TX_FILL, 0: word shifted out when no transmit word is pending.

- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- spi_cs_n  in  1  chip select, active low, asynchronous to clk.
- spi_sclk  in  1  serial clock, asynchronous to clk.
- spi_rx  in  1  controller-to-target data (MOSI).
- spi_tx  out  1  target-to-controller data (MISO).
- spi_tx_oe  out  1  output enable for spi_tx; equals `selected`.
- selected  out  1  synchronised chip select is asserted.
- frame_start  out  1  one-cycle pulse when the synchronised CS falls.
- frame_end  out  1  one-cycle pulse when the synchronised CS rises.
- rx_data  out  WIDTH  last complete received word; held until the next word completes.
- rx_valid  out  1  level; set when a word completes, cleared by rx_ack.
- rx_ack  in  1  consumer has taken rx_data.
- rx_overrun  out  1  one-cycle pulse: a word completed while rx_valid=1 and rx_ack=0.
- tx_data  in  WIDTH  next word to transmit.
- tx_wr  in  1  captures tx_data into the holding register.
- tx_pending  out  1  holding register is full and not yet loaded.
- tx_underrun  out  1  one-cycle pulse: a word load found tx_pending=0, so TX_FILL was used.

## Operation
- Synchronisation: each SPI input passes through SYNC_STAGES flops. Edges are detected by comparing the last synchronised stage with its delayed copy.
  - Leading edge: SCLK moves from CPOL to !CPOL.
  - Trailing edge: SCLK moves from !CPOL to CPOL.
  - Sample edge: leading if CPHA=0, trailing if CPHA=1. Shift edge is the other one.
- SCLK edges are ignored while `selected`=0.
- Receive path:
  - On each sample edge, the synchronised spi_rx is shifted into the receive shift register at the LSB end, and the bit counter (0..WIDTH-1) increments.
  - On the WIDTH-th sample edge, rx_data is loaded and the counter wraps to 0.
  - In the same cycle: rx_valid is set, and rx_overrun pulses if rx_valid was already 1 and rx_ack=0.
- Transmit path:
  - A word load copies the holding register into the transmit shift register and clears tx_pending. If tx_pending=0, TX_FILL is loaded and tx_underrun pulses.
  - spi_tx always drives the transmit shift register MSB.
  - Load points for CPHA=0:
    - the frame_start cycle;
    - the shift edge that follows a word's final sample edge, which loads the next word.
  - Load point for CPHA=1: the shift edge at bit counter 0, with the load and the MSB drive happening together.
  - Every other shift edge shifts the transmit register left by one.
- Holding register: tx_wr sets tx_pending and overwrites any value that was pending.
- CS rising mid-word: the partial word is discarded, with no rx_valid and no rx_overrun. The bit counter and both shift registers clear. The holding register and tx_pending are kept.

## Timing
- Reset values:
  - spi_tx=0, spi_tx_oe=0, selected=0.
  - frame_start, frame_end, rx_overrun, tx_underrun = 0.
  - rx_data=0, rx_valid=0, tx_pending=0.
  - Bit counter and both shift registers = 0.
  - Synchronisers reset to cs_n=1 and sclk=CPOL.
- Reset is asynchronous. Asserting it mid-frame aborts the frame. After release the block waits for a fresh CS falling edge; a frame already in progress is not resumed.
- Latency: a pin edge is registered SYNC_STAGES+1 clk cycles later.
  - rx_valid rises SYNC_STAGES+1 cycles after the final sample edge.
  - spi_tx updates SYNC_STAGES+1 cycles after a shift edge, or after the CS fall for CPHA=0.
- Constraints on the controller:
  - SCLK high and low phases each ≥ SYNC_STAGES+3 clk periods.
  - CS-fall-to-first-SCLK-edge and last-edge-to-CS-rise each ≥ SYNC_STAGES+3 clk periods.
  - Violations are unsupported.
- Simultaneous events:
  - rx_ack in the same cycle as a word completion: rx_valid stays 1, no overrun.
  - tx_wr in the same cycle as a load: the load takes the old contents (TX_FILL with an underrun pulse if nothing was pending), and the new write becomes pending.
  - frame_end and word completion never coincide, because of the CS setup constraint above.

## Test plan
- Mode 0, WIDTH=8, tx_wr 0xA5 before CS, controller sends 0x3C → rx_data=0x3C, rx_valid=1, MISO sampled as 0xA5, tx_pending=0 after frame_start.
- Modes 1/2/3 with the same stimulus → identical rx_data and MISO data; spi_tx changes only after shift edges.
- Two back-to-back words 0x11, 0x22 with rx_ack after each and 0x81 written during word 1 → rx_data sequence 0x11 then 0x22, MISO words 0xA5 then 0x81, no overrun/underrun.
- No tx_wr and no rx_ack across two words, TX_FILL=0xFF → MISO 0xFF; tx_underrun pulses at each load; rx_overrun pulses once at word 2, where rx_data=word 2.
- CS rises after 5 bits, then a new frame sends 0x5A → no rx_valid for the partial word; the next frame yields 0x5A; tx_pending is retained if it was set.
- WIDTH=16, reset asserted mid-word → all outputs at reset values immediately; after release, a full frame of 0xBEEF is received correctly.

Source files
------------

// File: rtl/spi_word_target.sv
// SPI target with oversampled pins: any CPOL/CPHA mode, WIDTH-bit words, back-to-back
// words per frame, buffered rx/tx handshakes with overrun/underrun pulses.
module spi_word_target #(
  parameter int unsigned      WIDTH       = 8,
  parameter bit               CPOL        = 1'b0,
  parameter bit               CPHA        = 1'b0,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] TX_FILL     = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spi_cs_n,
  input  logic             spi_sclk,
  input  logic             spi_rx,
  output logic             spi_tx,
  output logic             spi_tx_oe,
  output logic             selected,
  output logic             frame_start,
  output logic             frame_end,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ack,
  output logic             rx_overrun,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_wr,
  output logic             tx_pending,
  output logic             tx_underrun
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, rx_sync, live;
  logic                   cs_d, sclk_d, armed;
  logic [CNT_W-1:0]       bit_cnt;
  logic [WIDTH-1:0]       rx_shift, tx_shift, tx_hold;

  logic cs_s, sclk_s, rx_s;
  logic start_c, end_c, lead_c, trail_c, sample_c, shift_c, word_done_c, load_c;
  logic [WIDTH-1:0] rx_word_c;

  // Pin synchronisers; live marks when the chain holds real pin values rather than reset values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync   <= '1;
      sclk_sync <= {SYNC_STAGES{CPOL}};
      rx_sync   <= '0;
      live      <= '0;
      cs_d      <= 1'b1;
      sclk_d    <= CPOL;
      armed     <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      rx_sync   <= {rx_sync[SYNC_STAGES-2:0], spi_rx};
      live      <= {live[SYNC_STAGES-2:0], 1'b1};
      cs_d      <= cs_s;
      sclk_d    <= sclk_s;
      armed     <= armed | (live[SYNC_STAGES-1] & cs_s);
    end
  end

  // Edge classification; a frame only opens after CS has genuinely been seen high since reset.
  always_comb begin
    cs_s        = cs_sync[SYNC_STAGES-1];
    sclk_s      = sclk_sync[SYNC_STAGES-1];
    rx_s        = rx_sync[SYNC_STAGES-1];
    start_c     = armed & ~selected & cs_d & ~cs_s;
    end_c       = selected & cs_s;
    lead_c      = selected & (sclk_d == CPOL) & (sclk_s != CPOL);
    trail_c     = selected & (sclk_d != CPOL) & (sclk_s == CPOL);
    sample_c    = CPHA ? trail_c : lead_c;
    shift_c     = CPHA ? lead_c : trail_c;
    word_done_c = sample_c & (bit_cnt == LAST_BIT);
    // bit_cnt==0 at a shift edge means the next word starts here, for either phase
    load_c      = ((~CPHA) & start_c) | (shift_c & (bit_cnt == '0));
    rx_word_c   = {rx_shift[WIDTH-2:0], rx_s};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      selected    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      tx_hold     <= '0;
      tx_pending  <= 1'b0;
      tx_underrun <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      frame_start <= start_c;
      frame_end   <= end_c;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;

      if (start_c)    selected <= 1'b1;
      else if (end_c) selected <= 1'b0;

      if (end_c) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
        tx_shift <= '0;
      end else begin
        if (sample_c) begin
          rx_shift <= rx_word_c;
          bit_cnt  <= word_done_c ? '0 : bit_cnt + CNT_W'(1);
        end
        if (load_c) begin
          tx_shift    <= tx_pending ? tx_hold : TX_FILL;
          tx_underrun <= ~tx_pending;
        end else if (shift_c) begin
          tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
        end
      end

      if (word_done_c && !end_c) begin
        rx_data    <= rx_word_c;
        rx_valid   <= 1'b1;
        rx_overrun <= rx_valid & ~rx_ack;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end

      // A write coinciding with a load lands after the load has taken the old contents
      if (tx_wr) begin
        tx_hold    <= tx_data;
        tx_pending <= 1'b1;
      end else if (load_c && !end_c) begin
        tx_pending <= 1'b0;
      end
    end
  end

  assign spi_tx    = tx_shift[WIDTH-1];
  assign spi_tx_oe = selected;

endmodule

// File: tb/tb_spi_word_target.sv
// Directed bench: four 8-bit instances (SPI modes 0..3, fill 0xFF) and one 16-bit mode-0 instance.
module tb_spi_word_target;

  localparam int H = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic [15:0] tx_data;
  logic        cs_n [5];
  logic        sclk [5];
  logic        tx_wr [5];
  logic        rx_ack [5];
  logic        spi_tx [5];
  logic        oe [5];
  logic        sel [5];
  logic        fs [5];
  logic        fe [5];
  logic        ovr [5];
  logic        und [5];
  logic        rxv [5];
  logic        txp [5];
  logic [7:0]  rxd8 [4];
  logic [15:0] rxd16;

  int ovr_cnt [5] = '{default: 0};
  int und_cnt [5] = '{default: 0};
  int fs_cnt  [5] = '{default: 0};
  int fe_cnt  [5] = '{default: 0};
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_mode
    spi_word_target #(
      .WIDTH(8), .CPOL(m >= 2), .CPHA(m % 2 == 1), .SYNC_STAGES(2), .TX_FILL(8'hFF)
    ) dut (
      .clk(clk), .reset(reset), .spi_cs_n(cs_n[m]), .spi_sclk(sclk[m]), .spi_rx(rx),
      .spi_tx(spi_tx[m]), .spi_tx_oe(oe[m]), .selected(sel[m]), .frame_start(fs[m]),
      .frame_end(fe[m]), .rx_data(rxd8[m]), .rx_valid(rxv[m]), .rx_ack(rx_ack[m]),
      .rx_overrun(ovr[m]), .tx_data(tx_data[7:0]), .tx_wr(tx_wr[m]), .tx_pending(txp[m]),
      .tx_underrun(und[m])
    );
  end

  spi_word_target #(
    .WIDTH(16), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2), .TX_FILL(16'h0000)
  ) dut16 (
    .clk(clk), .reset(reset), .spi_cs_n(cs_n[4]), .spi_sclk(sclk[4]), .spi_rx(rx),
    .spi_tx(spi_tx[4]), .spi_tx_oe(oe[4]), .selected(sel[4]), .frame_start(fs[4]),
    .frame_end(fe[4]), .rx_data(rxd16), .rx_valid(rxv[4]), .rx_ack(rx_ack[4]),
    .rx_overrun(ovr[4]), .tx_data(tx_data), .tx_wr(tx_wr[4]), .tx_pending(txp[4]),
    .tx_underrun(und[4])
  );

  // Pulse counters for the one-cycle outputs
  always @(negedge clk) begin
    for (int k = 0; k < 5; k++) begin
      if (ovr[k]) ovr_cnt[k]++;
      if (und[k]) und_cnt[k]++;
      if (fs[k])  fs_cnt[k]++;
      if (fe[k])  fe_cnt[k]++;
    end
  end

  function automatic logic [15:0] rxd_of(input int i);
    return (i == 4) ? rxd16 : {8'h00, rxd8[i]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_wr(input int i, input logic [15:0] d);
    tx_data  = d;
    tx_wr[i] = 1'b1;
    tick(1);
    tx_wr[i] = 1'b0;
  endtask

  task automatic ack(input int i);
    rx_ack[i] = 1'b1;
    tick(1);
    rx_ack[i] = 1'b0;
  endtask

  task automatic cs_low(input int i);
    cs_n[i] = 1'b0;
    tick(H);
  endtask

  task automatic cs_high(input int i);
    cs_n[i] = 1'b1;
    tick(H);
  endtask

  // Controller side of one word (or the first nbits of it); returns the MISO bits sampled
  task automatic xfer(input int i, input logic [15:0] mosi, input int nbits, output logic [15:0] miso);
    int w    = (i == 4) ? 16 : 8;
    bit cpol = (i == 2 || i == 3);
    bit cpha = (i == 1 || i == 3);
    miso = '0;
    for (int b = 0; b < nbits; b++) begin
      if (!cpha) begin
        rx = mosi[w-1-b];
        tick(H);
        miso    = {miso[14:0], spi_tx[i]};
        sclk[i] = ~cpol;
        tick(H);
        sclk[i] = cpol;
      end else begin
        sclk[i] = ~cpol;
        rx      = mosi[w-1-b];
        tick(H);
        miso    = {miso[14:0], spi_tx[i]};
        sclk[i] = cpol;
        tick(H);
      end
    end
    tick(H);
  endtask

  initial begin
    logic [15:0] m1, m2;
    int u0, o0, f0;
    reset   = 1'b1;
    rx      = 1'b0;
    tx_data = '0;
    for (int i = 0; i < 5; i++) begin
      cs_n[i]   = 1'b1;
      sclk[i]   = (i == 2 || i == 3);
      tx_wr[i]  = 1'b0;
      rx_ack[i] = 1'b0;
    end
    tick(3);
    reset = 1'b0;
    tick(4);

    chk("reset_selected", 32'(sel[0]), 32'd0);
    chk("reset_oe", 32'(oe[0]), 32'd0);
    chk("reset_spi_tx", 32'(spi_tx[0]), 32'd0);
    chk("reset_rx_valid", 32'(rxv[4]), 32'd0);
    chk("reset_rx_data", 32'(rxd_of(4)), 32'd0);
    chk("reset_tx_pending", 32'(txp[0]), 32'd0);

    // Mode 0 basic word
    pulse_wr(0, 16'h00A5);
    chk("m0_pending_before_cs", 32'(txp[0]), 32'd1);
    cs_low(0);
    chk("m0_selected", 32'(sel[0]), 32'd1);
    chk("m0_oe", 32'(oe[0]), 32'd1);
    chk("m0_pending_after_start", 32'(txp[0]), 32'd0);
    chk("m0_first_miso_bit", 32'(spi_tx[0]), 32'd1);
    chk("m0_frame_start_cnt", 32'(fs_cnt[0]), 32'd1);
    xfer(0, 16'h003C, 8, m1);
    chk("m0_miso", 32'(m1), 32'h0A5);
    chk("m0_rx_data", 32'(rxd_of(0)), 32'h03C);
    chk("m0_rx_valid", 32'(rxv[0]), 32'd1);
    chk("m0_underrun_trailing_load", 32'(und_cnt[0]), 32'd1);
    chk("m0_overrun", 32'(ovr_cnt[0]), 32'd0);
    cs_high(0);
    chk("m0_deselected", 32'(sel[0]), 32'd0);
    chk("m0_frame_end_cnt", 32'(fe_cnt[0]), 32'd1);
    chk("m0_spi_tx_cleared", 32'(spi_tx[0]), 32'd0);
    ack(0);
    chk("m0_rx_valid_acked", 32'(rxv[0]), 32'd0);

    // Modes 1..3, same stimulus
    for (int i = 1; i < 4; i++) begin
      pulse_wr(i, 16'h00A5);
      cs_low(i);
      if (i % 2 == 1) begin
        chk("cpha1_no_load_at_start", 32'(spi_tx[i]), 32'd0);
        chk("cpha1_pending_at_start", 32'(txp[i]), 32'd1);
      end
      xfer(i, 16'h003C, 8, m1);
      chk("mode_miso", 32'(m1), 32'h0A5);
      chk("mode_rx_data", 32'(rxd_of(i)), 32'h03C);
      cs_high(i);
      ack(i);
    end

    // Mode 0 back-to-back words with acks and refills
    u0 = und_cnt[0];
    o0 = ovr_cnt[0];
    pulse_wr(0, 16'h00A5);
    cs_low(0);
    pulse_wr(0, 16'h0081);
    xfer(0, 16'h0011, 8, m1);
    chk("b2b_rx_word1", 32'(rxd_of(0)), 32'h011);
    ack(0);
    pulse_wr(0, 16'h0099);
    xfer(0, 16'h0022, 8, m2);
    chk("b2b_rx_word2", 32'(rxd_of(0)), 32'h022);
    chk("b2b_miso_word1", 32'(m1), 32'h0A5);
    chk("b2b_miso_word2", 32'(m2), 32'h081);
    ack(0);
    cs_high(0);
    chk("b2b_no_underrun", 32'(und_cnt[0] - u0), 32'd0);
    chk("b2b_no_overrun", 32'(ovr_cnt[0] - o0), 32'd0);

    // Mode 0 starved: fill words, underrun at each load, overrun at word 2
    u0 = und_cnt[0];
    o0 = ovr_cnt[0];
    cs_low(0);
    xfer(0, 16'h0012, 8, m1);
    xfer(0, 16'h0034, 8, m2);
    chk("starve_miso1", 32'(m1), 32'h0FF);
    chk("starve_miso2", 32'(m2), 32'h0FF);
    chk("starve_rx_data", 32'(rxd_of(0)), 32'h034);
    chk("starve_rx_valid", 32'(rxv[0]), 32'd1);
    chk("starve_overrun", 32'(ovr_cnt[0] - o0), 32'd1);
    chk("starve_underrun", 32'(und_cnt[0] - u0), 32'd3);
    cs_high(0);
    ack(0);

    // Mode 3 aborted partial word, then a clean frame
    o0 = ovr_cnt[3];
    cs_low(3);
    xfer(3, 16'h00E7, 5, m1);
    pulse_wr(3, 16'h00C3);
    cs_high(3);
    chk("abort_no_rx_valid", 32'(rxv[3]), 32'd0);
    chk("abort_rx_data_held", 32'(rxd_of(3)), 32'h03C);
    chk("abort_pending_kept", 32'(txp[3]), 32'd1);
    chk("abort_no_overrun", 32'(ovr_cnt[3] - o0), 32'd0);
    cs_low(3);
    xfer(3, 16'h005A, 8, m1);
    chk("abort_next_rx", 32'(rxd_of(3)), 32'h05A);
    chk("abort_next_miso", 32'(m1), 32'h0C3);
    cs_high(3);
    ack(3);

    // 16-bit: reset mid-word, no resume, then a fresh frame
    cs_low(4);
    xfer(4, 16'h1234, 16, m1);
    chk("w16_rx_word1", 32'(rxd_of(4)), 32'h1234);
    xfer(4, 16'hFFFF, 7, m1);
    pulse_wr(4, 16'hABCD);
    chk("w16_pending_before_reset", 32'(txp[4]), 32'd1);
    reset = 1'b1;
    #1;
    chk("w16_reset_selected", 32'(sel[4]), 32'd0);
    chk("w16_reset_oe", 32'(oe[4]), 32'd0);
    chk("w16_reset_rx_valid", 32'(rxv[4]), 32'd0);
    chk("w16_reset_rx_data", 32'(rxd_of(4)), 32'd0);
    chk("w16_reset_pending", 32'(txp[4]), 32'd0);
    tick(2);
    reset = 1'b0;
    f0 = fs_cnt[4];
    tick(2 * H);
    chk("w16_no_resume", 32'(sel[4]), 32'd0);
    chk("w16_no_frame_start", 32'(fs_cnt[4] - f0), 32'd0);
    cs_high(4);
    pulse_wr(4, 16'hCAFE);
    cs_low(4);
    xfer(4, 16'hBEEF, 16, m1);
    chk("w16_rx_beef", 32'(rxd_of(4)), 32'hBEEF);
    chk("w16_miso_cafe", 32'(m1), 32'hCAFE);
    chk("w16_rx_valid", 32'(rxv[4]), 32'd1);
    cs_high(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
